// File: rtl/sysbuf_pkg.sv
// rtl/sysbuf_pkg.sv - state encoding and default sizing for the systolic operand buffer
package sysbuf_pkg;
  localparam int SYSBUF_DATAWIDTH  = 256;
  localparam int SYSBUF_ROWS       = 512;
  localparam int SYSBUF_PAD        = 31;
  localparam int SYSBUF_ADDR_WIDTH = 10;
  localparam int SYSBUF_DEPTH      = SYSBUF_ROWS + SYSBUF_PAD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_LOADED,
    S_STREAM
  } sysbuf_state_e;
endpackage

// File: rtl/systolic_buffer_ctrl_if.sv
// rtl/systolic_buffer_ctrl_if.sv - producer row stream in, array row stream out
interface systolic_buffer_ctrl_if #(
  parameter int DATAWIDTH = sysbuf_pkg::SYSBUF_DATAWIDTH
);
  logic                 in_valid;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/systolic_internal_buffer.sv
// rtl/systolic_internal_buffer.sv - single-write-port row RAM with registered read
module systolic_internal_buffer #(
  parameter int DATAWIDTH  = 256,
  parameter int DEPTH      = 543,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]  rd_data
);
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/systolic_buffer_ctrl.sv
// rtl/systolic_buffer_ctrl.sv - load/pad/stream sequencer; SYSBUF_ZERO_WRITE_EN writes pad rows to RAM
module systolic_buffer_ctrl
  import sysbuf_pkg::*;
#(
  parameter int DATAWIDTH  = SYSBUF_DATAWIDTH,
  parameter int ROWS       = SYSBUF_ROWS,
  parameter int PAD        = SYSBUF_PAD,
  parameter int ADDR_WIDTH = SYSBUF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] cfg_rows,
  output logic                  cfg_err,
  input  logic                  stream_start,
  output logic                  loaded,
  output logic                  busy,
  systolic_buffer_ctrl_if.slave bus
);
  localparam int                  DEPTH  = ROWS + PAD;
  localparam int                  AW1    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] ROWS_W = AW1'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] PAD_A = ADDR_WIDTH'(PAD);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  if (ROWS + PAD > 2 ** ADDR_WIDTH) begin : g_cfg_check
    $error("systolic_buffer_ctrl: ROWS+PAD exceeds the address space");
  end

  sysbuf_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  valid_q, last_q;
  logic                  we;
  logic [DATAWIDTH-1:0]  wr_data;
  logic [DATAWIDTH-1:0]  rd_data;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  cfg_ok;

  assign last_addr = rows_q + PAD_A - ONE;
  assign cfg_ok    = (cfg_rows != '0) && ({1'b0, cfg_rows} <= ROWS_W);

  // One counter serves as write address in LOAD/PAD and read address in STREAM.
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    we        = 1'b0;
    wr_data   = bus.in_data;
    case (state_q)
      S_IDLE, S_LOADED: begin
        if (load_start) begin
          if (cfg_ok) begin
            state_d = S_LOAD;
            rows_d  = cfg_rows;
            cnt_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (stream_start && state_q == S_LOADED) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + ONE;
          if (cnt_q == rows_q - ONE) begin
`ifdef SYSBUF_ZERO_WRITE_EN
            state_d = S_PAD;
`else
            state_d = S_LOADED;
`endif
          end
        end
      end
`ifdef SYSBUF_ZERO_WRITE_EN
      S_PAD: begin
        we      = 1'b1;
        wr_data = '0;
        cnt_d   = cnt_q + ONE;
        if (cnt_q == last_addr) state_d = S_LOADED;
      end
`endif
      S_STREAM: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == last_addr) state_d = S_LOADED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      valid_q   <= (state_q == S_STREAM);
      last_q    <= (state_q == S_STREAM) && (cnt_q == last_addr);
    end
  end

  systolic_internal_buffer #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .wr_addr(cnt_q),
    .wr_data(wr_data),
    .rd_addr(cnt_q),
    .rd_data(rd_data)
  );

`ifdef SYSBUF_ZERO_WRITE_EN
  assign bus.out_data = rd_data;
`else
  // Pad rows were never written, so mask them in the read pipeline instead.
  logic pad_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pad_q <= 1'b0;
    else        pad_q <= (cnt_q >= rows_q);
  end
  assign bus.out_data = pad_q ? '0 : rd_data;
`endif

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign cfg_err       = cfg_err_q;
  assign loaded        = (state_q == S_LOADED);
  assign busy          = (state_q == S_LOAD) || (state_q == S_PAD) || (state_q == S_STREAM);
endmodule

// File: tb/tb_systolic_buffer_ctrl.sv
// tb/tb_systolic_buffer_ctrl.sv - directed bench with a row-queue model of the streamed output
module tb_systolic_buffer_ctrl;
  localparam int DW   = 256;
  localparam int AW   = 10;
  localparam int PADN = 31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          stream_start = 1'b0;
  logic [AW-1:0] cfg_rows = '0;
  logic          cfg_err, loaded, busy;

  systolic_buffer_ctrl_if #(.DATAWIDTH(DW)) bus ();

  systolic_buffer_ctrl #(
    .DATAWIDTH(DW), .ROWS(512), .PAD(PADN), .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .cfg_rows    (cfg_rows),
    .cfg_err     (cfg_err),
    .stream_start(stream_start),
    .loaded      (loaded),
    .busy        (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: what was loaded, and the rows a stream must deliver.
  logic [DW-1:0] mdl_mem [0:1023];
  int            mdl_rows = 0;
  logic [DW-1:0] mq [$];
  int            exp_first = 0;
  int            start_cyc = 0;

  logic [DW-1:0] cap  [0:1023];
  logic [DW-1:0] cap1 [0:1023];
  int            cap_n = 0;
  int            last_idx = -1;
  int            first_cyc = -1;

  logic          cmp_v, cmp_l;
  logic [DW-1:0] cmp_d;

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_v = (mq.size() > 0) && (cyc >= exp_first);
      cmp_l = 1'b0;
      cmp_d = '0;
      if (cmp_v) begin
        cmp_d = mq.pop_front();
        cmp_l = (mq.size() == 0);
      end
      chk("out_valid", DW'(bus.out_valid), DW'(cmp_v));
      chk("out_last", DW'(bus.out_last), DW'(cmp_l));
      if (cmp_v) chk("out_data", bus.out_data, cmp_d);
      if (bus.out_valid) begin
        if (cap_n == 0) first_cyc = cyc;
        if (cap_n < 1024) cap[cap_n] = bus.out_data;
        if (bus.out_last) last_idx = cap_n;
        cap_n++;
      end
    end
  end

  function automatic logic [DW-1:0] pat(input int i, input int mode);
    logic [DW-1:0] r;
    r = '0;
    case (mode)
      0: r = {DW{1'b1}};
      1: r = {32{8'(i + 1)}};
      default: for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(k);
    endcase
    return r;
  endfunction

  task automatic load_cmd(input int n, input bit with_stream);
    @(posedge clk); #1;
    cfg_rows     = AW'(n);
    load_start   = 1'b1;
    stream_start = with_stream;
    @(posedge clk); #1;
    load_start   = 1'b0;
    stream_start = 1'b0;
  endtask

  task automatic feed(input int n, input int mode, input bit toggle);
    int            i = 0;
    int            g = 0;
    bit            ph = 1'b1;
    logic          acc;
    logic [DW-1:0] d;
    while (i < n && g < 4 * n + 20) begin
      d = pat(i, mode);
      bus.in_valid = toggle ? ph : 1'b1;
      bus.in_data  = d;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        mdl_mem[i] = d;
        i++;
      end
      ph = ~ph;
      g++;
    end
    bus.in_valid = 1'b0;
    chk("load_accepted", DW'(i), DW'(n));
    mdl_rows = n;
    g = 0;
    while (!loaded && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("loaded_after_load", DW'(loaded), DW'(1));
  endtask

  task automatic stream_cmd();
    @(posedge clk); #1;
    stream_start = 1'b1;
    for (int i = 0; i < mdl_rows; i++) mq.push_back(mdl_mem[i]);
    for (int i = 0; i < PADN; i++) mq.push_back('0);
    exp_first = cyc + 2;
    start_cyc = cyc;
    cap_n     = 0;
    last_idx  = -1;
    first_cyc = -1;
    @(posedge clk); #1;
    stream_start = 1'b0;
  endtask

  task automatic stream_wait();
    int g = 0;
    while (mq.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("stream_done", DW'(mq.size()), '0);
    mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic bad_cfg(input int n, input bit exp_loaded);
    load_cmd(n, 1'b0);
    chk("cfg_err_pulse", DW'(cfg_err), DW'(1));
    chk("cfg_err_in_ready", DW'(bus.in_ready), DW'(0));
    chk("cfg_err_busy", DW'(busy), DW'(0));
    chk("cfg_err_loaded", DW'(loaded), DW'(exp_loaded));
    @(posedge clk); #1;
    chk("cfg_err_clear", DW'(cfg_err), DW'(0));
    chk("cfg_err_in_ready2", DW'(bus.in_ready), DW'(0));
  endtask

  initial begin
    int mism;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_last", DW'(bus.out_last), DW'(0));
    chk("rst_cfg_err", DW'(cfg_err), DW'(0));
    chk("rst_loaded", DW'(loaded), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;

    bad_cfg(0, 1'b0);
    bad_cfg(513, 1'b0);

    // Leave 0xFF in the addresses the 4-row load will use as padding.
    load_cmd(40, 1'b0);
    feed(40, 0, 1'b0);
    load_cmd(4, 1'b0);
    feed(4, 1, 1'b0);

    stream_cmd();
    stream_wait();
    chk("s4_count", DW'(cap_n), DW'(35));
    chk("s4_last_idx", DW'(last_idx), DW'(34));
    chk("s4_row0", cap[0], {32{8'h01}});
    chk("s4_row3", cap[3], {32{8'h04}});
    chk("s4_pad_first", cap[4], '0);
    chk("s4_pad_last", cap[34], '0);
    for (int i = 0; i < 35; i++) cap1[i] = cap[i];

    stream_cmd();
    stream_wait();
    mism = 0;
    for (int i = 0; i < 35; i++) if (cap[i] !== cap1[i]) mism++;
    chk("restream_identical", DW'(mism), '0);
    chk("restream_count", DW'(cap_n), DW'(35));

    bad_cfg(0, 1'b1);

    load_cmd(2, 1'b1);
    chk("simul_in_ready", DW'(bus.in_ready), DW'(1));
    chk("simul_loaded", DW'(loaded), DW'(0));
    chk("simul_busy", DW'(busy), DW'(1));
    feed(2, 1, 1'b0);

    load_cmd(512, 1'b0);
    feed(512, 2, 1'b1);
    stream_cmd();
    stream_wait();
    chk("s512_count", DW'(cap_n), DW'(543));
    chk("s512_last_idx", DW'(last_idx), DW'(542));
    chk("s512_first_latency", DW'(first_cyc - start_cyc), DW'(2));

    stream_cmd();
    begin
      int g = 0;
      while (cap_n < 10 && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("mid_reached_row10", DW'(cap_n), DW'(10));
    #1;
    rst_n = 1'b0;
    mq.delete();
    #1;
    chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("mid_rst_out_last", DW'(bus.out_last), DW'(0));
    chk("mid_rst_loaded", DW'(loaded), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_no_last_seen", DW'(last_idx), {DW{1'b1}});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_loaded", DW'(loaded), DW'(0));
    chk("post_rst_in_ready", DW'(bus.in_ready), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
